amp_seq_ctrl: RTL and testbench

Power-up and output-gain sequencer for the stereo equalizer output path. Holds the amplifier off until the filter sample queues are full (counted via the CODEC interface's valid strobe), then enables the amp with zero gain. It then soft-ramps the volume gain delivered to the equalizer engine up to the slide-pot value. In steady state it supplies the engine's volume input and handles mute ramp-down/ramp-up, removing pops at start-up and mute.

---
 rtl/amp_seq_ctrl_if.sv | 39 +++
 rtl/amp_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_amp_seq_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/amp_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : amp_seq_ctrl_if
// Description : Control/status bundle between the amplifier sequencer and its
//               surroundings (CODEC valid strobe, slide-pot volume, mute,
//               gain/amp/status outputs).
//               master modport : drives en/valid/volume/mute, reads status
//               slave  modport : the sequencer itself
//   en        1   sequencer enable (low forces IDLE)
//   valid     1   one-cycle strobe per stereo sample pair
//   volume    13  unsigned slide-pot volume target
//   mute      1   level, requests gain ramp-down to 0
//   vol_out   13  registered gain to the equalizer engine
//   amp_on    1   registered amplifier enable
//   q_ready   1   registered sample-queue-full flag
//   seq_state 2   IDLE=0, FILL=1, RAMP=2, RUN=3
// Revision    : 1.0  initial release
// ============================================================================
interface amp_seq_ctrl_if;
    logic        en;
    logic        valid;
    logic [12:0] volume;
    logic        mute;
    logic [12:0] vol_out;
    logic        amp_on;
    logic        q_ready;
    logic [1:0]  seq_state;

    modport master (
        output en, valid, volume, mute,
        input  vol_out, amp_on, q_ready, seq_state
    );

    modport slave (
        input  en, valid, volume, mute,
        output vol_out, amp_on, q_ready, seq_state
    );
endinterface
`default_nettype wire

// File: rtl/amp_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : amp_seq_ctrl
// Description : Power-up and output-gain sequencer for the stereo equalizer
//               output path. Keeps the amplifier off until FILL_CNT sample
//               pairs have been seen, then enables it at zero gain and
//               soft-ramps the gain to the slide-pot value. In steady state
//               the gain follows the pot; mute ramps the gain down to 0 and
//               release ramps it back up.
// Ports       : clk    system clock
//               rst_n  asynchronous active-low reset
//               bus    amp_seq_ctrl_if.slave (en, valid, volume, mute in;
//                      vol_out, amp_on, q_ready, seq_state out)
// Parameters  : FILL_CNT   valid strobes needed to fill the sample queues
//               RAMP_STEP  gain change per valid strobe while ramping
// Options     : SLEW_LIMIT_EN - when defined, RUN slews the gain toward the
//               pot value by at most RAMP_STEP per valid strobe instead of a
//               direct registered passthrough.
// Revision    : 1.0  initial release
// ============================================================================
module amp_seq_ctrl #(
    parameter int FILL_CNT  = 1024,
    parameter int RAMP_STEP = 64
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    amp_seq_ctrl_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RAMP = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    localparam logic [10:0] C_FILL_LAST = 11'(FILL_CNT - 1);
    localparam logic [13:0] C_STEP      = 14'(RAMP_STEP);

    state_t       r_state, w_state;
    logic [10:0]  r_cnt,   w_cnt;
    logic [12:0]  r_vol,   w_vol;
    logic         r_amp,   w_amp;
    logic         r_qrdy,  w_qrdy;

    // 14-bit arithmetic so the up-step cannot overflow and the down-step
    // can be tested for going below zero.
    logic [13:0]        w_vol_ext;
    logic [13:0]        w_up;
    logic signed [13:0] w_dn;

    assign w_vol_ext = {1'b0, bus.volume};
    assign w_up      = {1'b0, r_vol} + C_STEP;
    assign w_dn      = $signed({1'b0, r_vol}) - $signed(C_STEP);

`ifdef SLEW_LIMIT_EN
    logic [13:0] w_gap_up;
    logic [13:0] w_gap_dn;
    assign w_gap_up = w_vol_ext - {1'b0, r_vol};
    assign w_gap_dn = {1'b0, r_vol} - w_vol_ext;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_vol   <= '0;
            r_amp   <= 1'b0;
            r_qrdy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_vol   <= w_vol;
            r_amp   <= w_amp;
            r_qrdy  <= w_qrdy;
        end
    end

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_vol   = r_vol;
        w_amp   = r_amp;
        w_qrdy  = r_qrdy;

        if (!bus.en) begin
            // Disable wins over every other event.
            w_state = ST_IDLE;
            w_cnt   = '0;
            w_vol   = '0;
            w_amp   = 1'b0;
            w_qrdy  = 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // valid in this cycle is deliberately not counted.
                    w_state = ST_FILL;
                    w_cnt   = '0;
                    w_vol   = '0;
                    w_amp   = 1'b0;
                    w_qrdy  = 1'b0;
                end
                ST_FILL: begin
                    if (bus.valid) begin
                        if (r_cnt == C_FILL_LAST) begin
                            w_state = ST_RAMP;
                            w_amp   = 1'b1;
                            w_qrdy  = 1'b1;
                        end else if (r_cnt != 11'h7FF) begin
                            w_cnt = r_cnt + 11'd1;
                        end
                    end
                end
                ST_RAMP, ST_RUN: begin
                    if (bus.mute) begin
                        w_state = ST_RAMP;
                        if (bus.valid) begin
                            w_vol = (w_dn < 14'sd0) ? 13'd0 : w_dn[12:0];
                        end
                    end else if (r_state == ST_RAMP) begin
                        // Also covers the pot being lowered below the
                        // current gain: sum >= volume lands on volume.
                        if (bus.valid) begin
                            if (w_up >= w_vol_ext) begin
                                w_vol   = bus.volume;
                                w_state = ST_RUN;
                            end else begin
                                w_vol = w_up[12:0];
                            end
                        end
                    end else begin
`ifdef SLEW_LIMIT_EN
                        if (bus.valid) begin
                            if (bus.volume > r_vol) begin
                                w_vol = (w_gap_up <= C_STEP) ? bus.volume : w_up[12:0];
                            end else if (bus.volume < r_vol) begin
                                w_vol = (w_gap_dn <= C_STEP) ? bus.volume : w_dn[12:0];
                            end
                        end
`else
                        w_vol = bus.volume;
`endif
                    end
                end
                default: begin
                    w_state = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.vol_out   = r_vol;
    assign bus.amp_on    = r_amp;
    assign bus.q_ready   = r_qrdy;
    assign bus.seq_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_amp_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_amp_seq_ctrl
// Description : Self-checking bench for amp_seq_ctrl (FILL_CNT=4,
//               RAMP_STEP=256). A behavioural gain model tracks the expected
//               outputs; directed sequences pin exact values and a random
//               phase exercises en/valid/mute/volume interactions.
//               Build with SLEW_LIMIT_EN defined to check the slew option.
// Revision    : 1.0  initial release
// ============================================================================
module tb_amp_seq_ctrl;

    localparam int FILL = 4;
    localparam int STEP = 256;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int n_checks = 0;
    int n_fails  = 0;

    amp_seq_ctrl_if u_if ();

    amp_seq_ctrl #(
        .FILL_CNT  (FILL),
        .RAMP_STEP (STEP)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Behavioural model: phase 0 off, 1 counting samples, 2 ramping,
    // 3 tracking the pot. Gain rules written as min/max/clamp arithmetic.
    // ------------------------------------------------------------------
    int m_phase = 0;
    int m_seen  = 0;
    int m_gain  = 0;
    int m_amp   = 0;

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    always @(posedge clk or negedge rst_n) begin : b_model
        int ph, seen, g, amp, tgt;
        if (!rst_n || !u_if.en) begin
            m_phase <= 0;
            m_seen  <= 0;
            m_gain  <= 0;
            m_amp   <= 0;
        end else begin
            ph = m_phase; seen = m_seen; g = m_gain; amp = m_amp;
            tgt = int'(u_if.volume);
            if (ph == 0) begin
                ph = 1; seen = 0;
            end else if (ph == 1) begin
                if (u_if.valid) begin
                    seen = seen + 1;
                    if (seen >= FILL) begin ph = 2; amp = 1; end
                end
            end else if (u_if.mute) begin
                ph = 2;
                if (u_if.valid) g = (g - STEP > 0) ? g - STEP : 0;
            end else if (ph == 2) begin
                if (u_if.valid) begin
                    g = (g + STEP < tgt) ? g + STEP : tgt;
                    if (g == tgt) ph = 3;
                end
            end else begin
`ifdef SLEW_LIMIT_EN
                if (u_if.valid) g = g + clampi(tgt - g, -STEP, STEP);
`else
                g = tgt;
`endif
            end
            m_phase <= ph; m_seen <= seen; m_gain <= g; m_amp <= amp;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        chk("model.state",   int'(u_if.seq_state), m_phase);
        chk("model.vol_out", int'(u_if.vol_out),   m_gain);
        chk("model.amp_on",  int'(u_if.amp_on),    m_amp);
        chk("model.q_ready", int'(u_if.q_ready),   m_amp);
    endtask

    // One clock: compare at the falling edge, return 2 time units after
    // the rising edge so new inputs never race the sampling edge.
    task automatic step();
        @(negedge clk);
        cmp_model();
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse();
        u_if.valid = 1'b1;
        step();
        u_if.valid = 1'b0;
    endtask

    task automatic pulse_gap();
        pulse();
        idle(7);
    endtask

    task automatic chk_out(input string name, input int st, input int vol,
                           input int amp, input int qr);
        chk({name, ".state"},   int'(u_if.seq_state), st);
        chk({name, ".vol_out"}, int'(u_if.vol_out),   vol);
        chk({name, ".amp_on"},  int'(u_if.amp_on),    amp);
        chk({name, ".q_ready"}, int'(u_if.q_ready),   qr);
    endtask

    initial begin
        int k;
        int exp;
        bit reached;

        u_if.en     = 1'b0;
        u_if.valid  = 1'b0;
        u_if.volume = 13'd0;
        u_if.mute   = 1'b0;
        idle(3);
        rst_n = 1'b1;
        step();
        chk_out("reset", 0, 0, 0, 0);

        // en low: valid strobes must be ignored
        for (int i = 0; i < 10; i++) begin pulse(); idle(2); end
        chk_out("idle_hold", 0, 0, 0, 0);

        // Fill then ramp up to 1000
        u_if.en = 1'b1;
        u_if.volume = 13'd1000;
        step();
        chk_out("enter_fill", 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) pulse_gap();
        chk_out("fill_3", 1, 0, 0, 0);
        pulse();
        chk_out("fill_done", 2, 0, 1, 1);
        idle(7);
        pulse(); chk_out("ramp_256", 2, 256, 1, 1); idle(7);
        pulse(); chk_out("ramp_512", 2, 512, 1, 1); idle(7);
        pulse(); chk_out("ramp_768", 2, 768, 1, 1); idle(7);
        pulse(); chk_out("ramp_1000", 3, 1000, 1, 1); idle(7);

        // RUN: pot moves to 3000
        u_if.volume = 13'd3000;
`ifdef SLEW_LIMIT_EN
        for (k = 1; k <= 8; k++) begin
            pulse();
            exp = (1000 + 256 * k > 3000) ? 3000 : 1000 + 256 * k;
            chk("slew_up", int'(u_if.vol_out), exp);
            idle(3);
        end
`else
        step();
        chk_out("run_3000", 3, 3000, 1, 1);
`endif
        u_if.volume = 13'd600;
        for (int i = 0; i < 10; i++) begin pulse(); idle(3); end
        chk_out("run_600", 3, 600, 1, 1);

        // Mute ramp-down and release
        u_if.mute = 1'b1;
        pulse(); chk_out("mute_344", 2, 344, 1, 1); idle(5);
        pulse(); chk_out("mute_88", 2, 88, 1, 1); idle(5);
        pulse(); chk_out("mute_0", 2, 0, 1, 1); idle(5);
        u_if.mute = 1'b0;
        pulse(); chk_out("unmute_256", 2, 256, 1, 1); idle(5);
        pulse(); chk_out("unmute_512", 2, 512, 1, 1); idle(5);
        pulse(); chk_out("unmute_600", 3, 600, 1, 1); idle(5);

        // Drop en mid-ramp at 512
        u_if.mute = 1'b1;
        for (int i = 0; i < 3; i++) begin pulse(); idle(2); end
        u_if.mute = 1'b0;
        u_if.volume = 13'd1000;
        pulse(); idle(2);
        pulse();
        chk_out("pre_drop", 2, 512, 1, 1);
        u_if.en = 1'b0;
        step();
        chk_out("en_drop", 0, 0, 0, 0);
        u_if.en = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin pulse(); idle(2); end
        chk_out("refill_3", 1, 0, 0, 0);
        pulse();
        chk_out("refill_4", 2, 0, 1, 1);

        // Random phase
        for (int i = 0; i < 4000; i++) begin
            u_if.valid = !u_if.valid && ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 79) == 0) u_if.mute = ~u_if.mute;
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 3))
                    0:       u_if.volume = 13'd0;
                    1:       u_if.volume = 13'($urandom_range(1, 300));
                    default: u_if.volume = 13'($urandom_range(0, 8191));
                endcase
            end
            if (u_if.en && $urandom_range(0, 399) == 0) u_if.en = 1'b0;
            else if (!u_if.en && $urandom_range(0, 5) == 0) u_if.en = 1'b1;
            step();
        end

        // Reach RUN, then reset asynchronously between edges
        u_if.valid  = 1'b0;
        u_if.en     = 1'b1;
        u_if.mute   = 1'b0;
        u_if.volume = 13'd2000;
        reached = 1'b0;
        for (int i = 0; i < 200 && !reached; i++) begin
            pulse(); idle(1);
            if (m_phase == 3) reached = 1'b1;
        end
        chk("reach_run", int'(reached), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 0, 0, 0, 0);
        idle(2);
        rst_n = 1'b1;
        idle(3);
        chk_out("post_rst", 1, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
